decoder_pipe: RTL and testbench
===============================

Name: decoder_pipe

Overview:
- Parametrised, pipelined N-to-2^N one-hot decoder for register-file write-enable generation.
- Captures a write address at decode/issue and carries its one-hot enable down a LAT-stage shift pipeline, so the enable arrives aligned with writeback.
- Exposes a busy bitmap of all in-flight destination indices for hazard detection.
- Supports stall, flush, zero-register masking and reversed index mapping.

Parameters:
- SEL_W, 5, select width; output width is 2^SEL_W.
- LAT, 2, pipeline depth in cycles; legal range 1..4.
- MASK_ZERO, 1, when 1 a decoded index of 2^SEL_W-1 (XZR) is suppressed.
- REVERSE, 0, when 1 select value k drives bit 2^SEL_W-1-k instead of bit k.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  capture request for sel this cycle.
- sel  input  SEL_W  destination index.
- stall  input  1  hold all pipeline stages.
- flush  input  1  clear all pipeline stages.
- o  output  2^SEL_W  one-hot write enable from the final stage, registered.
- valid_out  output  1  high when o is non-zero.
- busy  output  2^SEL_W  OR of the one-hots in all LAT stages.

Behaviour:
- Reset, synchronous on the clk edge with reset=1: all stages clear; o=0, valid_out=0, busy=0. Reset overrides stall, flush and en.
- Decode: idx = REVERSE ? (2^SEL_W-1-sel) : sel. Stage-0 input = en ? (1<<idx) : 0.
- Masking: the masking check uses the mapped index. With MASK_ZERO=1 and idx==2^SEL_W-1, the stage-0 input is 0. The request is silently dropped and never appears on busy.
- Pipeline: each edge with no stall/flush/reset, stage[0] <= decoded input and stage[i] <= stage[i-1]. o = stage[LAT-1]; valid_out = |stage[LAT-1].
- Latency: a request sampled at edge E appears on o after edge E+LAT-1. It is visible for exactly one cycle unless stalled.
- busy = OR of stage[0..LAT-1]. It is high from the cycle after capture through the cycle o is asserted.
- Stall, priority below reset and flush: all stages hold, and en is not captured (upstream must hold the request). o and valid_out hold their values, so an output held by stall remains asserted.
- Flush, priority below reset, above stall: all stages clear at the edge. A simultaneous en request is dropped.
- Each stage holds at most one bit set, giving one write per cycle. Duplicate indices in different stages are legal, and busy ORs them.
- LAT=1: o is stage[0] directly; busy equals o.

Optional Feature:
- Macro: DECODER_PIPE_WAW_DET_EN.
- With the macro defined: adds output port waw_err (1 bit). It is a sticky flag, set at the edge at which a non-masked request is captured whose one-hot overlaps stage[0..LAT-2]. A flag set at edge E is visible from the cycle after E. Captures that occur while flush or reset is active are ignored. Only reset clears the flag.
- Without the macro: no port and no logic. Behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=1 for 2 cycles with en=1, sel=3 -> o=0, valid_out=0, busy=0 throughout and on the first cycle after release.
- Single write (SEL_W=5, LAT=2): en=1, sel=3 at edge 0, then en=0.
  - busy=32'h8 in the cycles after edges 0 and 1.
  - o=32'h8 and valid_out=1 only in the cycle after edge 1.
  - All outputs 0 after edge 2.
- Masking: en=1, sel=31, MASK_ZERO=1 -> o=0, valid_out=0, busy=0 for 4 cycles. Repeat with REVERSE=1 and sel=0 -> same result.
- Back-to-back requests: sel=1, 2, 4 on consecutive edges -> o=32'h2, 32'h4, 32'h10 in three consecutive cycles. busy=32'h6 and then 32'h14 in the intermediate cycles.
- Stall and flush:
  - sel=5 is captured; stall=1 for 3 cycles -> busy=32'h20 held, o=0.
  - Release the stall -> o=32'h20 one cycle later.
  - Repeat, then assert flush with en=1, sel=7 at the same edge -> all outputs 0 the next cycle and 7 never appears.
- WAW detection (with DECODER_PIPE_WAW_DET_EN): sel=9 then sel=9 on consecutive edges -> waw_err=1 from the second capture onward and held until reset. Without the macro, the same stimulus yields o=32'h200 for 2 consecutive cycles.

Source files
------------

// File: rtl/decoder_pipe.sv
// Pipelined SEL_W-to-2^SEL_W one-hot write-enable decoder with stall/flush and busy bitmap.
// Optional macro DECODER_PIPE_WAW_DET_EN adds a sticky write-after-write hazard flag (waw_err).
module decoder_pipe #(
  parameter int SEL_W     = 5,
  parameter int LAT       = 2,
  parameter int MASK_ZERO = 1,
  parameter int REVERSE   = 0,
  localparam int N        = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic             stall,
  input  logic             flush,
  output logic [N-1:0]     o,
  output logic             valid_out,
  output logic [N-1:0]     busy
`ifdef DECODER_PIPE_WAW_DET_EN
  ,
  output logic             waw_err
`endif
);

  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("decoder_pipe: LAT must be in 1..4");
  end

  logic [SEL_W-1:0] idx;
  logic             masked;
  logic [N-1:0]     dec_next;
  logic [N-1:0]     stage_reg [LAT];
  logic [N-1:0]     busy_acc [LAT+1];

  // 2^SEL_W-1-sel is simply the bitwise complement of sel.
  assign idx    = (REVERSE != 0) ? ~sel : sel;
  assign masked = (MASK_ZERO != 0) && (idx == {SEL_W{1'b1}});

  always_comb begin
    dec_next = '0;
    if (en && !masked) begin
      dec_next = {{(N-1){1'b0}}, 1'b1} << idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < LAT; i++) begin
        stage_reg[i] <= '0;
      end
    end else if (!stall) begin
      stage_reg[0] <= dec_next;
      for (int i = 1; i < LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  // Prefix OR chain: busy_acc[k] covers stages 0..k-1.
  assign busy_acc[0] = '0;
  for (genvar gi = 0; gi < LAT; gi++) begin : g_busy
    assign busy_acc[gi+1] = busy_acc[gi] | stage_reg[gi];
  end

  assign o         = stage_reg[LAT-1];
  assign valid_out = |stage_reg[LAT-1];
  assign busy      = busy_acc[LAT];

`ifdef DECODER_PIPE_WAW_DET_EN
  logic waw_err_reg;

  // Compare against stages that have not yet reached writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      waw_err_reg <= 1'b0;
    end else if (!flush && !stall && ((dec_next & busy_acc[LAT-1]) != '0)) begin
      waw_err_reg <= 1'b1;
    end
  end

  assign waw_err = waw_err_reg;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed testbench for decoder_pipe: request-queue reference model checked every cycle,
// plus hand-computed literal expectations. Covers a normal and a REVERSE=1 instance.
module tb_decoder_pipe;
  localparam int SEL_W = 5;
  localparam int LAT   = 2;
  localparam int N     = 1 << SEL_W;

  logic             clk = 1'b0;
  logic             reset, en, stall, flush;
  logic [SEL_W-1:0] sel, sel_r;
  logic [N-1:0]     o0, b0, o1, b1;
  logic             v0, v1;
`ifdef DECODER_PIPE_WAW_DET_EN
  logic             waw0, waw1;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  decoder_pipe #(.SEL_W(SEL_W), .LAT(LAT), .MASK_ZERO(1), .REVERSE(0)) dut (
    .clk(clk), .reset(reset), .en(en), .sel(sel), .stall(stall), .flush(flush),
    .o(o0), .valid_out(v0), .busy(b0)
`ifdef DECODER_PIPE_WAW_DET_EN
    , .waw_err(waw0)
`endif
  );

  decoder_pipe #(.SEL_W(SEL_W), .LAT(LAT), .MASK_ZERO(1), .REVERSE(1)) dut_r (
    .clk(clk), .reset(reset), .en(en), .sel(sel_r), .stall(stall), .flush(flush),
    .o(o1), .valid_out(v1), .busy(b1)
`ifdef DECODER_PIPE_WAW_DET_EN
    , .waw_err(waw1)
`endif
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a list of in-flight write requests, each tagged with its age.
  typedef struct {
    int           inst;
    logic [N-1:0] oh;
    int           age;
  } ent_t;

  ent_t         mq[$];
  ent_t         nq[$];
  ent_t         e;
  bit           mvalid = 1'b0;
  bit           m_waw [2];
  int           idx;
  logic [N-1:0] oh;

  initial begin
    m_waw[0] = 1'b0;
    m_waw[1] = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_waw[0] = 1'b0;
        m_waw[1] = 1'b0;
        mvalid   = 1'b1;
      end else if (flush) begin
        mq.delete();
      end else if (!stall) begin
        nq.delete();
        foreach (mq[i]) begin
          if (mq[i].age < LAT-1) begin
            e     = mq[i];
            e.age = e.age + 1;
            nq.push_back(e);
          end
        end
        for (int k = 0; k < 2; k++) begin
          idx = (k == 1) ? (N - 1 - int'(sel_r)) : int'(sel);
          if (en && idx != N-1) begin
            oh      = '0;
            oh[idx] = 1'b1;
            foreach (mq[i]) begin
              if (mq[i].inst == k && mq[i].age < LAT-1 && (mq[i].oh & oh) != '0) m_waw[k] = 1'b1;
            end
            e.inst = k;
            e.oh   = oh;
            e.age  = 0;
            nq.push_back(e);
          end
        end
        mq = nq;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  logic [N-1:0] exp_o [2];
  logic [N-1:0] exp_b [2];
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        exp_o[0] = '0; exp_o[1] = '0; exp_b[0] = '0; exp_b[1] = '0;
        foreach (mq[i]) begin
          exp_b[mq[i].inst] = exp_b[mq[i].inst] | mq[i].oh;
          if (mq[i].age == LAT-1) exp_o[mq[i].inst] = exp_o[mq[i].inst] | mq[i].oh;
        end
        chk("model_o",      o0, exp_o[0]);
        chk("model_valid",  {31'b0, v0}, {31'b0, exp_o[0] != '0});
        chk("model_busy",   b0, exp_b[0]);
        chk("model_o_r",    o1, exp_o[1]);
        chk("model_valid_r",{31'b0, v1}, {31'b0, exp_o[1] != '0});
        chk("model_busy_r", b1, exp_b[1]);
`ifdef DECODER_PIPE_WAW_DET_EN
        chk("model_waw",    {31'b0, waw0}, {31'b0, m_waw[0]});
        chk("model_waw_r",  {31'b0, waw1}, {31'b0, m_waw[1]});
`endif
      end
    end
  end

  task automatic step(input logic r, input logic e_i, input int s, input int sr,
                      input logic st, input logic fl);
    reset = r; en = e_i; sel = SEL_W'(s); sel_r = SEL_W'(sr); stall = st; flush = fl;
    @(posedge clk);
    #1;
    $display("step reset=%0b en=%0b sel=%0d sel_r=%0d stall=%0b flush=%0b -> o=%h busy=%h",
             r, e_i, s, sr, st, fl, o0, b0);
  endtask

  task automatic lit(string nm, logic [31:0] o_exp, logic [31:0] b_exp);
    chk({nm, "_o"}, o0, o_exp);
    chk({nm, "_valid"}, {31'b0, v0}, {31'b0, o_exp != 0});
    chk({nm, "_busy"}, b0, b_exp);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sel = '0; sel_r = '1; stall = 1'b0; flush = 1'b0;
    #2;
    // Reset holds everything clear even with a request present.
    step(1, 1, 3, 31, 0, 0); lit("reset1", 0, 0);
    step(1, 1, 3, 31, 0, 0); lit("reset2", 0, 0);
    step(0, 0, 0, 31, 0, 0); lit("reset_rel", 0, 0);

    // Single write of index 3.
    step(0, 1, 3, 31, 0, 0); lit("single_e0", 0, 32'h8);
    step(0, 0, 0, 31, 0, 0); lit("single_e1", 32'h8, 32'h8);
    step(0, 0, 0, 31, 0, 0); lit("single_e2", 0, 0);

    // Masked index on both mappings.
    step(0, 1, 31, 0, 0, 0); lit("mask0", 0, 0);
    chk("mask_r_busy", b1, 0);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0); lit("mask", 0, 0);
      chk("mask_r_o", o1, 0);
    end

    // Back-to-back captures.
    step(0, 1, 1, 31, 0, 0); lit("b2b_1", 0, 32'h2);
    step(0, 1, 2, 31, 0, 0); lit("b2b_2", 32'h2, 32'h6);
    step(0, 1, 4, 31, 0, 0); lit("b2b_3", 32'h4, 32'h14);
    step(0, 0, 0, 31, 0, 0); lit("b2b_4", 32'h10, 32'h10);
    step(0, 0, 0, 31, 0, 0); lit("b2b_5", 0, 0);

    // Stall with request mid-pipe, then release.
    step(0, 1, 5, 31, 0, 0); lit("stall_cap", 0, 32'h20);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5, 31, 1, 0); lit("stall_hold", 0, 32'h20);
    end
    step(0, 0, 0, 31, 0, 0); lit("stall_rel", 32'h20, 32'h20);
    step(0, 0, 0, 31, 0, 0); lit("stall_done", 0, 0);

    // Stall holding an asserted output.
    step(0, 1, 6, 31, 0, 0); lit("ohold_cap", 0, 32'h40);
    step(0, 0, 0, 31, 0, 0); lit("ohold_out", 32'h40, 32'h40);
    step(0, 0, 0, 31, 1, 0); lit("ohold_st1", 32'h40, 32'h40);
    step(0, 0, 0, 31, 1, 0); lit("ohold_st2", 32'h40, 32'h40);
    step(0, 0, 0, 31, 0, 0); lit("ohold_rel", 0, 0);

    // Flush drops both the in-flight and the simultaneous request.
    step(0, 1, 5, 31, 0, 0); lit("flush_cap", 0, 32'h20);
    step(0, 1, 7, 31, 0, 1); lit("flush_e", 0, 0);
    step(0, 0, 0, 31, 0, 0); lit("flush_p1", 0, 0);
    step(0, 0, 0, 31, 0, 0); lit("flush_p2", 0, 0);

`ifdef DECODER_PIPE_WAW_DET_EN
    chk("waw_pre", {31'b0, waw0}, 0);
`endif
    // Same destination on consecutive edges.
    step(0, 1, 9, 31, 0, 0); lit("waw_1", 0, 32'h200);
    step(0, 1, 9, 31, 0, 0); lit("waw_2", 32'h200, 32'h200);
`ifdef DECODER_PIPE_WAW_DET_EN
    chk("waw_set", {31'b0, waw0}, 1);
`endif
    step(0, 0, 0, 31, 0, 0); lit("waw_3", 32'h200, 32'h200);
    step(0, 0, 0, 31, 0, 0); lit("waw_4", 0, 0);
`ifdef DECODER_PIPE_WAW_DET_EN
    chk("waw_sticky", {31'b0, waw0}, 1);
`endif
    step(1, 0, 0, 31, 0, 0); lit("final_reset", 0, 0);
`ifdef DECODER_PIPE_WAW_DET_EN
    chk("waw_clr", {31'b0, waw0}, 0);
`endif
    step(0, 0, 0, 31, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
